// File: rtl/button_int_ctrl.sv
// Key conditioner for CPU interrupts: sync, debounce, latch presses,
// and present one pending event at a time, highest index first.
module button_int_ctrl #(
  parameter int NUM_BTN         = 4,
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter int CNT_W           = 20
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [NUM_BTN-1:0] keys_n,
  input  logic               int_busy,
  input  logic               int_ack,
  output logic [NUM_BTN-1:0] buttons_pressed,
  output logic [NUM_BTN-1:0] pending,
  output logic [NUM_BTN-1:0] btn_stable
);

  localparam logic [CNT_W-1:0] TERM = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic [NUM_BTN-1:0] sync1;
  logic [NUM_BTN-1:0] sync2;
  logic [NUM_BTN-1:0] stable_d;
  logic [NUM_BTN-1:0] rise;
  logic [NUM_BTN-1:0] sel;
  logic [NUM_BTN-1:0] ack_mask;
  logic               ack_hit;

  // Reset to "released" so a key held through reset yields one press.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1 <= '0;
      sync2 <= '0;
    end else begin
      sync1 <= ~keys_n;
      sync2 <= sync1;
    end
  end

  for (genvar i = 0; i < NUM_BTN; i++) begin : g_deb
    logic [CNT_W-1:0] cnt;
    logic             stb;

    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        cnt <= '0;
        stb <= 1'b0;
      end else if (sync2[i] == stb) begin
        cnt <= '0;
      end else if (cnt == TERM) begin
        stb <= sync2[i];
        cnt <= '0;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end

    assign btn_stable[i] = stb;
  end

  always_comb begin
    sel = '0;
    for (int k = 0; k < NUM_BTN; k++) begin
      if (pending[k]) sel = NUM_BTN'(1) << k;
    end
  end

  assign ack_hit  = int_ack & (|buttons_pressed);
  assign ack_mask = ack_hit ? buttons_pressed : '0;
  assign rise     = btn_stable & ~stable_d;

  // A fresh press wins over an ack of the same bit.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stable_d        <= '0;
      pending         <= '0;
      buttons_pressed <= '0;
    end else begin
      stable_d        <= btn_stable;
      pending         <= (pending & ~ack_mask) | rise;
      buttons_pressed <= (int_busy | ack_hit) ? '0 : sel;
    end
  end

endmodule

// File: tb/tb_button_int_ctrl.sv
// Bench for button_int_ctrl: directed vector table, reset sequence,
// and randomized traffic against a reference model.
module tb_button_int_ctrl;

  localparam int N = 4;
  localparam int D = 4;

  logic         clk = 1'b0;
  logic         rst;
  logic [N-1:0] keys_n;
  logic         int_busy;
  logic         int_ack;
  logic [N-1:0] buttons_pressed;
  logic [N-1:0] pending;
  logic [N-1:0] btn_stable;

  int n_assert = 0;
  int n_fail   = 0;

  button_int_ctrl #(
    .NUM_BTN(N),
    .DEBOUNCE_CYCLES(D),
    .CNT_W(3)
  ) dut (
    .clk(clk),
    .rst(rst),
    .keys_n(keys_n),
    .int_busy(int_busy),
    .int_ack(int_ack),
    .buttons_pressed(buttons_pressed),
    .pending(pending),
    .btn_stable(btn_stable)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [N-1:0] keys;
    logic         busy;
    logic         ack;
    int           cycles;
    logic [N-1:0] e_stab;
    logic [N-1:0] e_pend;
    logic [N-1:0] e_bp;
  } vec_t;

  vec_t vt[$];

  // Reference model: levels per key, run length of disagreement.
  logic [N-1:0] m_s1, m_s2, m_stab, m_prev, m_pend, m_bp;
  int           m_run[N];

  function automatic logic [N-1:0] highest(logic [N-1:0] p);
    for (int k = N - 1; k >= 0; k--)
      if (p[k]) return N'(1) << k;
    return '0;
  endfunction

  task automatic model_reset();
    m_s1 = '0; m_s2 = '0; m_stab = '0;
    m_prev = '0; m_pend = '0; m_bp = '0;
    for (int k = 0; k < N; k++) m_run[k] = 0;
  endtask

  task automatic model_step();
    logic         ah;
    logic [N-1:0] np, nb;
    ah = int_ack && (m_bp != 0);
    np = (m_pend & ~(ah ? m_bp : '0)) | (m_stab & ~m_prev);
    nb = (int_busy || ah) ? '0 : highest(m_pend);
    m_prev = m_stab;
    for (int k = 0; k < N; k++) begin
      if (m_s2[k] != m_stab[k]) begin
        m_run[k]++;
        if (m_run[k] == D) begin
          m_stab[k] = m_s2[k];
          m_run[k] = 0;
        end
      end else begin
        m_run[k] = 0;
      end
    end
    m_s2 = m_s1;
    m_s1 = ~keys_n;
    m_pend = np;
    m_bp = nb;
  endtask

  task automatic tick(int n);
    repeat (n) begin
      @(posedge clk);
      if (rst) model_reset();
      else model_step();
    end
    #1;
  endtask

  task automatic chk(string nm, logic [N-1:0] act, logic [N-1:0] exp);
    n_assert++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %b expected %b at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic chk3(string nm, logic [N-1:0] s, logic [N-1:0] p,
                      logic [N-1:0] b);
    chk({nm, ".stable"}, btn_stable, s);
    chk({nm, ".pending"}, pending, p);
    chk({nm, ".bp"}, buttons_pressed, b);
  endtask

  task automatic add(logic [N-1:0] k, logic b, logic a, int c,
                     logic [N-1:0] s, logic [N-1:0] p, logic [N-1:0] o);
    vec_t v;
    v.keys = k; v.busy = b; v.ack = a; v.cycles = c;
    v.e_stab = s; v.e_pend = p; v.e_bp = o;
    vt.push_back(v);
  endtask

  initial begin
    // T1: single key, latency and ack
    add(4'hB, 0, 0, 5, 4'h0, 4'h0, 4'h0);
    add(4'hB, 0, 0, 1, 4'h4, 4'h0, 4'h0);
    add(4'hB, 0, 0, 1, 4'h4, 4'h4, 4'h0);
    add(4'hB, 0, 0, 1, 4'h4, 4'h4, 4'h4);
    add(4'hB, 0, 1, 1, 4'h4, 4'h0, 4'h0);
    add(4'hB, 0, 0, 3, 4'h4, 4'h0, 4'h0);
    add(4'hF, 0, 0, 8, 4'h0, 4'h0, 4'h0);
    // T2: short glitch rejected
    add(4'hE, 0, 0, 3, 4'h0, 4'h0, 4'h0);
    add(4'hF, 0, 0, 1, 4'h0, 4'h0, 4'h0);
    add(4'hF, 0, 0, 1, 4'h0, 4'h0, 4'h0);
    add(4'hF, 0, 0, 6, 4'h0, 4'h0, 4'h0);
    // T3: two keys, priority and ack gap
    add(4'h5, 0, 0, 6, 4'hA, 4'h0, 4'h0);
    add(4'h5, 0, 0, 1, 4'hA, 4'hA, 4'h0);
    add(4'h5, 0, 0, 1, 4'hA, 4'hA, 4'h8);
    add(4'h5, 0, 1, 1, 4'hA, 4'h2, 4'h0);
    add(4'h5, 0, 0, 1, 4'hA, 4'h2, 4'h2);
    add(4'h5, 0, 1, 1, 4'hA, 4'h0, 4'h0);
    add(4'h5, 0, 0, 2, 4'hA, 4'h0, 4'h0);
    add(4'hF, 0, 0, 8, 4'h0, 4'h0, 4'h0);
    // T4: busy masks presentation
    add(4'hE, 1, 0, 7, 4'h1, 4'h1, 4'h0);
    add(4'hE, 1, 0, 3, 4'h1, 4'h1, 4'h0);
    add(4'hE, 0, 0, 1, 4'h1, 4'h1, 4'h1);
    add(4'hE, 0, 1, 1, 4'h1, 4'h0, 4'h0);
    add(4'hF, 0, 0, 8, 4'h0, 4'h0, 4'h0);
    // T5: ignored acks, ack vs. new press on one edge
    add(4'hF, 0, 1, 1, 4'h0, 4'h0, 4'h0);
    add(4'hD, 1, 0, 8, 4'h2, 4'h2, 4'h0);
    add(4'hD, 1, 1, 1, 4'h2, 4'h2, 4'h0);
    add(4'hD, 0, 0, 1, 4'h2, 4'h2, 4'h2);
    add(4'hD, 0, 1, 1, 4'h2, 4'h0, 4'h0);
    add(4'hF, 0, 0, 8, 4'h0, 4'h0, 4'h0);
    add(4'hE, 0, 0, 8, 4'h1, 4'h1, 4'h1);
    add(4'hF, 0, 0, 6, 4'h0, 4'h1, 4'h1);
    add(4'hE, 0, 0, 6, 4'h1, 4'h1, 4'h1);
    add(4'hE, 0, 1, 1, 4'h1, 4'h1, 4'h0);
    add(4'hE, 0, 0, 1, 4'h1, 4'h1, 4'h1);
    add(4'hE, 0, 1, 1, 4'h1, 4'h0, 4'h0);
    add(4'hF, 0, 0, 8, 4'h0, 4'h0, 4'h0);

    rst = 1'b1; keys_n = '1; int_busy = 1'b0; int_ack = 1'b0;
    model_reset();
    tick(3);
    chk3("reset", 4'h0, 4'h0, 4'h0);
    rst = 1'b0;

    for (int v = 0; v < vt.size(); v++) begin
      keys_n = vt[v].keys;
      int_busy = vt[v].busy;
      int_ack = vt[v].ack;
      tick(vt[v].cycles);
      chk3($sformatf("vec%0d", v), vt[v].e_stab, vt[v].e_pend, vt[v].e_bp);
    end
    int_ack = 1'b0;

    // T6: async reset mid-count with events pending
    keys_n = 4'h9;
    tick(8);
    chk3("t6.pre", 4'h6, 4'h6, 4'h4);
    keys_n = 4'hD;
    tick(3);
    chk("t6.mid", btn_stable, 4'h6);
    #2;
    rst = 1'b1;
    model_reset();
    #1;
    chk3("t6.async", 4'h0, 4'h0, 4'h0);
    tick(1);
    rst = 1'b0;
    tick(5);
    chk3("t6.r5", 4'h0, 4'h0, 4'h0);
    tick(1);
    chk3("t6.r6", 4'h2, 4'h0, 4'h0);
    tick(1);
    chk3("t6.r7", 4'h2, 4'h2, 4'h0);
    tick(1);
    chk3("t6.r8", 4'h2, 4'h2, 4'h2);

    // Randomized traffic against the model
    for (int c = 0; c < 800; c++) begin
      for (int k = 0; k < N; k++)
        if ($urandom_range(0, 9) == 0) keys_n[k] = ~keys_n[k];
      int_busy = ($urandom_range(0, 4) == 0);
      int_ack = ($urandom_range(0, 3) == 0);
      tick(1);
      chk3($sformatf("rnd%0d", c), m_stab, m_pend, m_bp);
    end

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_assert, n_fail);
    $finish;
  end

endmodule
